router_local_input_port: RTL and testbench
==========================================

Name: router_local_input_port

Overview:
- Router-side terminus of the NIC→router link: receives flits driven on the NIC's out_link_o/is_valid_o and buffers them per virtual channel.
- Returns per-VC credit_signal and free_signal pulses, which feed the NIC's credit_signal_i/free_signal_i vectors.
- Presents the head flit of each VC to the router's switch allocator and dequeues on grant.
- Enforces the per-VC packet protocol and flags overflow and framing violations.

Parameters:
- FLIT_WIDTH, 64, flit width; must match `FLIT_WIDTH.
- N_TOT_OF_VC, 4, total VCs (`N_OF_VC*`N_OF_VN).
- BUFFER_DEPTH, 4, flits per VC FIFO; equals `MAX_CREDIT; power of two.
- N_BITS_VC_ID, 2, clog2(N_TOT_OF_VC).
- N_BITS_POINTER, 2, clog2(BUFFER_DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_link_i  in  FLIT_WIDTH  flit from the NIC.
- is_valid_i  in  1  in_link_i valid this cycle.
- credit_signal_o  out  N_TOT_OF_VC  one-cycle pulse per VC: one buffer slot released.
- free_signal_o  out  N_TOT_OF_VC  one-cycle pulse per VC: tail dequeued, VC reusable.
- head_valid_o  out  N_TOT_OF_VC  VC FIFO non-empty.
- read_i  in  1  switch allocator grants a dequeue this cycle.
- read_vc_i  in  N_BITS_VC_ID  VC to dequeue.
- flit_o  out  FLIT_WIDTH  head flit of VC read_vc_i (combinational mux).
- overflow_err_o  out  1  sticky: write to a full VC.
- framing_err_o  out  1  sticky: flit type illegal for the VC state.

Behaviour:
- Flit fields: type = flit[FLIT_WIDTH-1:FLIT_WIDTH-2], encoded BODY=00, TAIL=01, HEAD=10, HEADTAIL=11. VC id = next N_BITS_VC_ID bits below type.
- Reset values: all outputs 0, all FIFOs empty, pointers 0, every VC in RX_IDLE. flit_o reads the storage of FIFO slot 0; its value is don't-care while head_valid_o[read_vc_i]=0.
- Write: on is_valid_i, flit is written at the tail of the FIFO for its VC id, visible on head_valid_o the next cycle (latency 1).
- Read: read_i with head_valid_o[read_vc_i]=1 pops that FIFO at the clock edge.
  - credit_signal_o[read_vc_i] pulses high in the cycle after the pop (registered).
  - If the popped flit is TAIL or HEADTAIL, free_signal_o[read_vc_i] pulses in the same cycle as the credit.
- read_i on an empty VC is ignored: no pop, no pulse.
- Simultaneous write and read on the same VC:
  - allowed when full (pop and push both happen, count unchanged);
  - allowed when empty: the read is ignored, because head_valid_o is 0 that cycle.
- Full VC with write and no pop in the same cycle: flit dropped, overflow_err_o set; pointers unchanged.
- Pointers are N_BITS_POINTER wide and wrap naturally. The per-VC count is N_BITS_POINTER+1 bits, range 0..BUFFER_DEPTH.
- Per-VC receive FSM, advanced on accepted writes:
  - RX_IDLE: HEAD→RX_ACTIVE; HEADTAIL→RX_IDLE; BODY/TAIL→framing_err_o set, flit still stored, stay RX_IDLE.
  - RX_ACTIVE: BODY→RX_ACTIVE; TAIL→RX_IDLE; HEAD/HEADTAIL→framing_err_o set, flit stored, state restarts per type (HEAD→RX_ACTIVE, HEADTAIL→RX_IDLE).
- Error flags are cleared only by rst.
- rst asserted mid-packet: immediately empties all FIFOs, returns all FSMs to RX_IDLE and drops pending credit/free pulses. The NIC resets in the same domain, so its credit counters re-align.

Decomposition:
- Shared package (NIC-defines.v) holds:
  - flit type codes (`FLIT_TYPE_BODY/TAIL/HEAD/HEADTAIL);
  - type and VC-id field offsets;
  - `MAX_CREDIT, `N_OF_VC, `N_OF_VN, `FLIT_WIDTH;
  - clog2 from NIC_utils.vh.
- One sub-module, vc_flit_fifo: a single-VC circular buffer with push, pop, full, empty, head data and popped-type output. Instantiated N_TOT_OF_VC times by generate.
- The receive FSM, credit/free registers and output mux live in the top.

Test Plan:
- Single-flit packet: HEADTAIL on VC2 at cycle 0 → head_valid_o=4'b0100 at cycle 1. Then read_i, read_vc_i=2 at cycle 2 → credit_signal_o=4'b0100 and free_signal_o=4'b0100 at cycle 3, head_valid_o=0.
- Four-flit packet on VC1 (H,B,B,T), then 4 reads → four credit pulses on bit1; free_signal_o[1] pulses only with the 4th credit; flit_o data matches the written order.
- Overflow: 5 flits to VC0 with no reads → 5th dropped, overflow_err_o=1; the 4 stored flits read back intact.
- Full VC0 with write and read in the same cycle → no overflow, count stays 4, one credit pulse.
- Framing: BODY to an idle VC3 → framing_err_o=1, flit stored. HEAD while VC0 is RX_ACTIVE → framing_err_o stays 1.
- Reset with flits on VC0 and VC2 plus a pending credit → next cycle all head_valid_o=0 and no credit/free pulses. A new HEAD on VC0 is accepted with no framing error.

Source files
------------

// File: rtl/router_local_input_port_pkg.sv
// Shared definitions for the router local input port.
// Holds the flit type codes, the link geometry that must agree with the NIC
// (flit width, VC count, credit depth), the per-VC receive state encoding and
// a couple of small helpers. No ports; imported by the port and its FIFO.
package router_local_input_port_pkg;

  localparam int FLIT_WIDTH  = 64;
  localparam int N_OF_VC     = 2;
  localparam int N_OF_VN     = 2;
  localparam int N_TOT_OF_VC = N_OF_VC * N_OF_VN;
  localparam int MAX_CREDIT  = 4;

  // Type field sits in the two MSBs, the VC id immediately below it.
  localparam int TYPE_W = 2;

  typedef enum logic [1:0] {
    FLIT_BODY     = 2'b00,
    FLIT_TAIL     = 2'b01,
    FLIT_HEAD     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } flit_type_t;

  typedef enum logic {
    RX_IDLE   = 1'b0,
    RX_ACTIVE = 1'b1
  } rx_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // TAIL and HEADTAIL both close a packet and release the VC.
  function automatic logic is_tail(input logic [1:0] t);
    return (t == FLIT_TAIL) || (t == FLIT_HEADTAIL);
  endfunction

endpackage

// File: rtl/router_local_input_port_vc_flit_fifo.sv
// Single-VC circular flit buffer.
// Ports: clk/rst (async, active high); push/wdata enqueue; pop dequeues the
// head; full/empty status from the occupancy count; head is the flit at the
// read pointer; head_type is that flit's type field (the type being popped
// when pop is high).
// A push while full is only taken when a pop happens in the same cycle, so the
// slot being vacated is refilled and the occupancy stays at DEPTH.
module vc_flit_fifo
  import router_local_input_port_pkg::*;
#(
  parameter int FLIT_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [FLIT_WIDTH-1:0] wdata,
  output logic                  full,
  output logic                  empty,
  output logic [FLIT_WIDTH-1:0] head,
  output logic [TYPE_W-1:0]     head_type
);

  logic [DEPTH-1:0][FLIT_WIDTH-1:0] mem;
  logic [PTR_W-1:0]                 wr_ptr, rd_ptr;
  logic [PTR_W:0]                   count;
  logic                             wr_en, rd_en;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign wr_en     = push && (!full || pop);
  assign rd_en     = pop && !empty;
  assign head      = mem[rd_ptr];
  assign head_type = head[FLIT_WIDTH-1 -: TYPE_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/router_local_input_port.sv
// Router-side end of the NIC->router link.
// Ports: clk/rst (async, active high); in_link_i/is_valid_i incoming flit;
// credit_signal_o/free_signal_o per-VC pulses back to the NIC (slot released /
// tail dequeued); head_valid_o per-VC non-empty; read_i/read_vc_i dequeue
// grant from the switch allocator; flit_o head flit of read_vc_i;
// overflow_err_o/framing_err_o sticky protocol error flags.
module router_local_input_port
  import router_local_input_port_pkg::*;
#(
  parameter int FLIT_WIDTH     = 64,
  parameter int N_TOT_OF_VC    = 4,
  parameter int BUFFER_DEPTH   = 4,
  parameter int N_BITS_VC_ID   = 2,
  parameter int N_BITS_POINTER = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FLIT_WIDTH-1:0]   in_link_i,
  input  logic                    is_valid_i,
  output logic [N_TOT_OF_VC-1:0]  credit_signal_o,
  output logic [N_TOT_OF_VC-1:0]  free_signal_o,
  output logic [N_TOT_OF_VC-1:0]  head_valid_o,
  input  logic                    read_i,
  input  logic [N_BITS_VC_ID-1:0] read_vc_i,
  output logic [FLIT_WIDTH-1:0]   flit_o,
  output logic                    overflow_err_o,
  output logic                    framing_err_o
);

  localparam int TYPE_LSB = FLIT_WIDTH - TYPE_W;
  localparam int VC_LSB   = TYPE_LSB - N_BITS_VC_ID;

  logic [N_BITS_VC_ID-1:0]                 wr_vc;
  flit_type_t                              wr_type;
  logic [N_TOT_OF_VC-1:0]                  push, pop, full, empty, accept, tail_pop;
  logic [N_TOT_OF_VC-1:0][FLIT_WIDTH-1:0]  head;
  logic [N_TOT_OF_VC-1:0][TYPE_W-1:0]      head_type;
  rx_state_t [N_TOT_OF_VC-1:0]             rx_q, rx_d;
  logic [N_TOT_OF_VC-1:0]                  frame_bad;
  logic                                    ovf_hit;

  assign wr_vc   = in_link_i[VC_LSB +: N_BITS_VC_ID];
  assign wr_type = flit_type_t'(in_link_i[TYPE_LSB +: TYPE_W]);

  for (genvar g = 0; g < N_TOT_OF_VC; g++) begin : g_vc
    assign push[g]     = is_valid_i && (wr_vc == N_BITS_VC_ID'(g));
    // Gating on !empty makes a grant to an empty VC (including one being
    // written this very cycle) a no-op.
    assign pop[g]      = read_i && (read_vc_i == N_BITS_VC_ID'(g)) && !empty[g];
    assign accept[g]   = push[g] && (!full[g] || pop[g]);
    assign tail_pop[g] = pop[g] && is_tail(head_type[g]);

    vc_flit_fifo #(
      .FLIT_WIDTH (FLIT_WIDTH),
      .DEPTH      (BUFFER_DEPTH),
      .PTR_W      (N_BITS_POINTER)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[g]),
      .pop       (pop[g]),
      .wdata     (in_link_i),
      .full      (full[g]),
      .empty     (empty[g]),
      .head      (head[g]),
      .head_type (head_type[g])
    );
  end

  assign head_valid_o = ~empty;
  assign flit_o       = head[read_vc_i];
  assign ovf_hit      = |(push & full & ~pop);

  // Receive FSM: a flagged flit is still stored, and the state restarts
  // according to the offending flit's own type.
  always_comb begin
    rx_d      = rx_q;
    frame_bad = '0;
    for (int i = 0; i < N_TOT_OF_VC; i++) begin
      if (accept[i]) begin
        case (rx_q[i])
          RX_IDLE: begin
            case (wr_type)
              FLIT_HEAD:     rx_d[i] = RX_ACTIVE;
              FLIT_HEADTAIL: rx_d[i] = RX_IDLE;
              default:       frame_bad[i] = 1'b1;
            endcase
          end
          default: begin
            case (wr_type)
              FLIT_BODY:     rx_d[i] = RX_ACTIVE;
              FLIT_TAIL:     rx_d[i] = RX_IDLE;
              FLIT_HEAD: begin
                frame_bad[i] = 1'b1;
                rx_d[i]      = RX_ACTIVE;
              end
              default: begin
                frame_bad[i] = 1'b1;
                rx_d[i]      = RX_IDLE;
              end
            endcase
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q            <= {N_TOT_OF_VC{RX_IDLE}};
      credit_signal_o <= '0;
      free_signal_o   <= '0;
      overflow_err_o  <= 1'b0;
      framing_err_o   <= 1'b0;
    end else begin
      rx_q            <= rx_d;
      credit_signal_o <= pop;
      free_signal_o   <= tail_pop;
      overflow_err_o  <= overflow_err_o | ovf_hit;
      framing_err_o   <= framing_err_o | (|frame_bad);
    end
  end

endmodule

// File: tb/tb_router_local_input_port.sv
module tb_router_local_input_port;
  import router_local_input_port_pkg::*;

  localparam int FW = 64;
  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] in_link_i = '0;
  logic          is_valid_i = 1'b0;
  logic [NV-1:0] credit_signal_o, free_signal_o, head_valid_o;
  logic          read_i = 1'b0;
  logic [1:0]    read_vc_i = '0;
  logic [FW-1:0] flit_o;
  logic          overflow_err_o, framing_err_o;

  router_local_input_port dut (
    .clk(clk), .rst(rst), .in_link_i(in_link_i), .is_valid_i(is_valid_i),
    .credit_signal_o(credit_signal_o), .free_signal_o(free_signal_o),
    .head_valid_o(head_valid_o), .read_i(read_i), .read_vc_i(read_vc_i),
    .flit_o(flit_o), .overflow_err_o(overflow_err_o), .framing_err_o(framing_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per VC, a "packet open" bit per VC, sticky flags
  // and the pulses expected in the cycle after each edge.
  logic [FW-1:0] q [NV][$];
  bit            pkt_open [NV];
  bit            m_ovf, m_frm;
  logic [NV-1:0] m_credit, m_free;
  logic [FW-1:0] obs_flit, exp_head;
  bit            exp_head_ok;

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [1:0] vc);
    logic [59:0] p;
    p = 60'({$urandom(), $urandom()});
    return {t, vc, p};
  endfunction

  function automatic logic [NV-1:0] m_hv();
    logic [NV-1:0] r;
    for (int i = 0; i < NV; i++) r[i] = (q[i].size() != 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      q[i].delete();
      pkt_open[i] = 0;
    end
    m_ovf = 0; m_frm = 0; m_credit = '0; m_free = '0;
  endtask

  // One clock of stimulus; records flit_o before the edge and advances the model.
  task automatic drive(input bit v, input logic [FW-1:0] f, input bit rd, input logic [1:0] rvc);
    logic [FW-1:0] popped;
    logic [1:0]    t;
    int            wvc;
    is_valid_i = v; in_link_i = f; read_i = rd; read_vc_i = rvc;
    #1;
    obs_flit    = flit_o;
    exp_head_ok = (q[rvc].size() != 0);
    exp_head    = exp_head_ok ? q[rvc][0] : '0;
    @(posedge clk);
    m_credit = '0; m_free = '0;
    if (rd && q[rvc].size() != 0) begin
      popped = q[rvc].pop_front();
      m_credit[rvc] = 1'b1;
      m_free[rvc]   = popped[FW-2];   // low type bit set for TAIL and HEADTAIL
    end
    if (v) begin
      wvc = int'(f[FW-3 -: 2]);
      t   = f[FW-1 -: 2];
      if (q[wvc].size() < MAX_CREDIT) begin
        q[wvc].push_back(f);
        // A head must start a packet, a non-head must continue one.
        if (t[1] == pkt_open[wvc]) m_frm = 1;
        pkt_open[wvc] = (t[1] | pkt_open[wvc]) & ~t[0];
      end else begin
        m_ovf = 1;
      end
    end
    #1;
    is_valid_i = 0; read_i = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (head_valid_o !== '0) begin errors++; $display("FAIL reset_hv got %b exp 0000", head_valid_o); end
    checks++; if (credit_signal_o !== '0 || free_signal_o !== '0) begin errors++; $display("FAIL reset_pulses got %b/%b exp 0", credit_signal_o, free_signal_o); end
    checks++; if (overflow_err_o !== 1'b0 || framing_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b/%b exp 0/0", overflow_err_o, framing_err_o); end
    checks++; if (flit_o !== '0) begin errors++; $display("FAIL reset_flit got %h exp 0", flit_o); end
    rst = 0;
    model_reset();
  endtask

  task automatic test_single();
    logic [FW-1:0] f;
    f = mk(FLIT_HEADTAIL, 2);
    drive(1, f, 0, 0);
    checks++; if (head_valid_o !== 4'b0100) begin errors++; $display("FAIL single_hv got %b exp 0100", head_valid_o); end
    drive(0, '0, 1, 2);
    checks++; if (obs_flit !== f) begin errors++; $display("FAIL single_flit got %h exp %h", obs_flit, f); end
    checks++; if (credit_signal_o !== 4'b0100 || free_signal_o !== 4'b0100) begin errors++; $display("FAIL single_pulse got %b/%b exp 0100/0100", credit_signal_o, free_signal_o); end
    checks++; if (head_valid_o !== 4'b0000) begin errors++; $display("FAIL single_hv_after got %b exp 0000", head_valid_o); end
    drive(0, '0, 1, 2);   // empty VC: ignored
    checks++; if (credit_signal_o !== '0 || free_signal_o !== '0) begin errors++; $display("FAIL empty_read got %b/%b exp 0/0", credit_signal_o, free_signal_o); end
  endtask

  task automatic test_four_flit();
    logic [FW-1:0] f [4];
    logic [1:0]    ty [4];
    ty[0] = FLIT_HEAD; ty[1] = FLIT_BODY; ty[2] = FLIT_BODY; ty[3] = FLIT_TAIL;
    for (int k = 0; k < 4; k++) begin
      f[k] = mk(ty[k], 1);
      drive(1, f[k], 0, 0);
    end
    checks++; if (head_valid_o !== 4'b0010) begin errors++; $display("FAIL four_hv got %b exp 0010", head_valid_o); end
    for (int k = 0; k < 4; k++) begin
      drive(0, '0, 1, 1);
      checks++; if (obs_flit !== f[k]) begin errors++; $display("FAIL four_flit%0d got %h exp %h", k, obs_flit, f[k]); end
      checks++; if (credit_signal_o !== 4'b0010) begin errors++; $display("FAIL four_credit%0d got %b exp 0010", k, credit_signal_o); end
      checks++; if (free_signal_o !== ((k == 3) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL four_free%0d got %b exp %b", k, free_signal_o, (k == 3) ? 4'b0010 : 4'b0000); end
    end
    checks++; if (framing_err_o !== 1'b0) begin errors++; $display("FAIL four_frm got %b exp 0", framing_err_o); end
  endtask

  task automatic test_full_rw();
    logic [FW-1:0] f [5];
    logic [FW-1:0] e [4];
    for (int k = 0; k < 5; k++) f[k] = mk(FLIT_HEADTAIL, 0);
    for (int k = 0; k < 4; k++) drive(1, f[k], 0, 0);
    drive(1, f[4], 1, 0);   // full: pop and push together
    checks++; if (obs_flit !== f[0]) begin errors++; $display("FAIL fullrw_flit got %h exp %h", obs_flit, f[0]); end
    checks++; if (overflow_err_o !== 1'b0) begin errors++; $display("FAIL fullrw_ovf got %b exp 0", overflow_err_o); end
    checks++; if (credit_signal_o !== 4'b0001) begin errors++; $display("FAIL fullrw_credit got %b exp 0001", credit_signal_o); end
    e[0] = f[1]; e[1] = f[2]; e[2] = f[3]; e[3] = f[4];
    for (int k = 0; k < 4; k++) begin
      checks++; if (head_valid_o[0] !== 1'b1) begin errors++; $display("FAIL fullrw_hv%0d got %b exp 1", k, head_valid_o[0]); end
      drive(0, '0, 1, 0);
      checks++; if (obs_flit !== e[k]) begin errors++; $display("FAIL fullrw_data%0d got %h exp %h", k, obs_flit, e[k]); end
    end
    checks++; if (head_valid_o[0] !== 1'b0) begin errors++; $display("FAIL fullrw_drain got %b exp 0", head_valid_o[0]); end
  endtask

  task automatic test_overflow();
    logic [FW-1:0] f [5];
    for (int k = 0; k < 5; k++) begin
      f[k] = mk(FLIT_HEADTAIL, 0);
      drive(1, f[k], 0, 0);
      if (k == 3) begin
        checks++; if (overflow_err_o !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", overflow_err_o); end
      end
    end
    checks++; if (overflow_err_o !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", overflow_err_o); end
    for (int k = 0; k < 4; k++) begin
      drive(0, '0, 1, 0);
      checks++; if (obs_flit !== f[k]) begin errors++; $display("FAIL ovf_data%0d got %h exp %h", k, obs_flit, f[k]); end
    end
    checks++; if (head_valid_o[0] !== 1'b0) begin errors++; $display("FAIL ovf_drain got %b exp 0", head_valid_o[0]); end
    checks++; if (overflow_err_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow_err_o); end
  endtask

  task automatic test_framing();
    logic [FW-1:0] f;
    f = mk(FLIT_BODY, 3);
    checks++; if (framing_err_o !== 1'b0) begin errors++; $display("FAIL frm_pre got %b exp 0", framing_err_o); end
    drive(1, f, 0, 0);
    checks++; if (framing_err_o !== 1'b1) begin errors++; $display("FAIL frm_body got %b exp 1", framing_err_o); end
    checks++; if (head_valid_o[3] !== 1'b1) begin errors++; $display("FAIL frm_stored got %b exp 1", head_valid_o[3]); end
    drive(0, '0, 1, 3);
    checks++; if (obs_flit !== f) begin errors++; $display("FAIL frm_data got %h exp %h", obs_flit, f); end
    drive(1, mk(FLIT_HEAD, 0), 0, 0);
    drive(1, mk(FLIT_HEAD, 0), 0, 0);
    checks++; if (framing_err_o !== 1'b1) begin errors++; $display("FAIL frm_sticky got %b exp 1", framing_err_o); end
  endtask

  task automatic test_reset_mid();
    drive(1, mk(FLIT_HEADTAIL, 2), 1, 0);   // VC0 still holds the two heads
    checks++; if (credit_signal_o !== 4'b0001) begin errors++; $display("FAIL rmid_credit got %b exp 0001", credit_signal_o); end
    rst = 1;
    #1;
    checks++; if (credit_signal_o !== '0 || head_valid_o !== '0) begin errors++; $display("FAIL rmid_async got %b/%b exp 0/0", credit_signal_o, head_valid_o); end
    @(posedge clk); #1;
    checks++; if (head_valid_o !== '0 || credit_signal_o !== '0 || free_signal_o !== '0) begin errors++; $display("FAIL rmid_clear got %b/%b/%b exp 0", head_valid_o, credit_signal_o, free_signal_o); end
    checks++; if (framing_err_o !== 1'b0 || overflow_err_o !== 1'b0) begin errors++; $display("FAIL rmid_err got %b/%b exp 0/0", framing_err_o, overflow_err_o); end
    rst = 0;
    model_reset();
    drive(1, mk(FLIT_HEAD, 0), 0, 0);
    checks++; if (framing_err_o !== 1'b0 || head_valid_o !== 4'b0001) begin errors++; $display("FAIL rmid_head got %b/%b exp 0/0001", framing_err_o, head_valid_o); end
    drive(1, mk(FLIT_TAIL, 0), 1, 0);
    drive(0, '0, 1, 0);
    checks++; if (free_signal_o !== 4'b0001 || framing_err_o !== 1'b0) begin errors++; $display("FAIL rmid_tail got %b/%b exp 0001/0", free_signal_o, framing_err_o); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 99) < 60), mk(2'($urandom()), 2'($urandom())),
            ($urandom_range(0, 99) < 50), 2'($urandom()));
      if (exp_head_ok) begin
        checks++; if (obs_flit !== exp_head) begin errors++; $display("FAIL rnd_flit@%0d got %h exp %h", n, obs_flit, exp_head); end
      end
      checks++; if (head_valid_o !== m_hv()) begin errors++; $display("FAIL rnd_hv@%0d got %b exp %b", n, head_valid_o, m_hv()); end
      checks++; if (credit_signal_o !== m_credit || free_signal_o !== m_free) begin errors++; $display("FAIL rnd_pulse@%0d got %b/%b exp %b/%b", n, credit_signal_o, free_signal_o, m_credit, m_free); end
      checks++; if (overflow_err_o !== m_ovf || framing_err_o !== m_frm) begin errors++; $display("FAIL rnd_err@%0d got %b/%b exp %b/%b", n, overflow_err_o, framing_err_o, m_ovf, m_frm); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_four_flit();
    test_full_rw();
    test_overflow();
    test_framing();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
